buf_mux_sequencer: RTL and testbench

- Time-shares the single on-chip analog unity buffer between N_CH analog pad requesters.
- Owns the analog mux switch enables that connect a selected input pad to the buffer input.
- Enforces break-before-make dead time, then a settle interval, before signalling the output valid.
- Digital control block only; sits beside the buffer and mux in the top-level wrapper and is driven from ui_in / uio pins.

---
 rtl/buf_seq_pkg.sv | 32 +++
 rtl/buf_mux_sequencer_rr_arbiter.sv | 46 ++++
 rtl/buf_mux_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_buf_mux_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/buf_seq_pkg.sv
// ---------------------------------------------------------------------------
// buf_seq_pkg
// Shared definitions for the analog buffer mux sequencer:
//   - state_e      : sequencer states (IDLE, BREAK_IN, SETTLE, ACTIVE, BREAK_OUT)
//   - cnt_width()  : width of the shared down-counter, sized to hold the
//                    largest of the dead, settle and hold intervals
//   - DEF_*        : default parameter values
// ---------------------------------------------------------------------------
package buf_seq_pkg;

    localparam int DEF_N_CH       = 4;
    localparam int DEF_DEAD_CYC   = 2;
    localparam int DEF_SETTLE_CYC = 8;
    localparam int DEF_HOLD_MAX   = 64;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_BREAK_IN  = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_ACTIVE    = 3'd3,
        ST_BREAK_OUT = 3'd4
    } state_e;

    // Bits needed to hold max(dead, settle, hold) as an unsigned count.
    function automatic int cnt_width(input int dead_cyc, input int settle_cyc, input int hold_max);
        int m;
        m = (settle_cyc > dead_cyc) ? settle_cyc : dead_cyc;
        m = (hold_max > m) ? hold_max : m;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/buf_mux_sequencer_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. Searches i_req starting at index i_ptr,
// wrapping around, and returns the first set bit.
// Ports:
//   i_req    [N_CH-1:0]   request vector
//   i_ptr    [IDX_W-1:0]  index with highest priority (must be < N_CH)
//   o_winner [N_CH-1:0]   one-hot winner, zero when no request
//   o_idx    [IDX_W-1:0]  winner index, zero when no request
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_CH  = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_CH-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_CH-1:0]  o_winner,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_pos;
    logic             w_hit;
    logic             w_found;

    // Walk the channels in priority order from i_ptr; the first requester wins.
    always_comb begin
        o_winner = {N_CH{1'b0}};
        o_idx    = {IDX_W{1'b0}};
        w_found  = 1'b0;
        w_sum    = {(IDX_W+1){1'b0}};
        w_pos    = {IDX_W{1'b0}};
        w_hit    = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
            // Wrap modulo N_CH without a divider: i_ptr + k < 2*N_CH.
            w_sum = (w_sum >= (IDX_W+1)'(N_CH)) ? (w_sum - (IDX_W+1)'(N_CH)) : w_sum;
            w_pos = w_sum[IDX_W-1:0];
            w_hit = !w_found && i_req[w_pos];
            o_winner[w_pos] = w_hit;
            o_idx   = w_hit ? w_pos : o_idx;
            w_found = w_found | w_hit;
        end
    end

endmodule

// File: rtl/buf_mux_sequencer.sv
// ---------------------------------------------------------------------------
// buf_mux_sequencer
// Time-shares the single analog unity buffer between N_CH pad requesters.
// Drives the analog mux switch enables with break-before-make dead time and
// a settle interval before flagging the buffer output as ready.
//
// Optional feature (macro BUF_SEQ_TIMEOUT_EN): an owner that has held ACTIVE
// for HOLD_MAX cycles is preempted when any other channel is requesting.
// Without the macro, preempt is tied low and the owner keeps the buffer
// until its request drops.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   req      in   [N_CH] per-channel level request, held for the transaction
//   grant    out  [N_CH] one-hot owner (zero when no owner)
//   sw_en    out  [N_CH] analog switch enables, identical to grant
//   ready    out  buffer output settled for the owner
//   busy     out  sequencer not in IDLE
//   preempt  out  one-cycle pulse on forced release
// All outputs are registered.
// ---------------------------------------------------------------------------
module buf_mux_sequencer
    import buf_seq_pkg::*;
#(
    parameter int N_CH       = DEF_N_CH,
    parameter int DEAD_CYC   = DEF_DEAD_CYC,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int HOLD_MAX   = DEF_HOLD_MAX
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] req,
    output logic [N_CH-1:0] grant,
    output logic [N_CH-1:0] sw_en,
    output logic            ready,
    output logic            busy,
    output logic            preempt
);

    localparam int CW    = cnt_width(DEAD_CYC, SETTLE_CYC, HOLD_MAX);
    localparam int IDX_W = $clog2(N_CH);

    localparam logic [CW-1:0]    C_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0]    C_ONE    = CW'(1);
    localparam logic [CW-1:0]    C_DEAD   = CW'(DEAD_CYC);
    localparam logic [CW-1:0]    C_SETTLE = CW'(SETTLE_CYC);
`ifdef BUF_SEQ_TIMEOUT_EN
    localparam logic [CW-1:0]    C_HOLD   = CW'(HOLD_MAX);
`endif
    localparam logic [IDX_W-1:0] C_IDX0   = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] C_IDX1   = IDX_W'(1);
    localparam logic [IDX_W-1:0] C_LAST   = IDX_W'(N_CH - 1);
    localparam logic [N_CH-1:0]  C_LSB    = N_CH'(1);

    state_e           r_state;
    logic [CW-1:0]    r_cnt;
    logic [IDX_W-1:0] r_sel;
    logic [IDX_W-1:0] r_ptr;
    logic [N_CH-1:0]  r_owner;
    logic             r_ready;
    logic             r_busy;
    logic             r_preempt;

    state_e           w_state_next;
    logic [CW-1:0]    w_cnt_next;
    logic [IDX_W-1:0] w_sel_next;
    logic [IDX_W-1:0] w_ptr_next;
    logic             w_preempt_next;
    logic [N_CH-1:0]  w_owner_next;
    logic [N_CH-1:0]  w_arb_winner;
    logic [IDX_W-1:0] w_arb_idx;
    logic             w_req_sel;
    logic [IDX_W-1:0] w_ptr_inc;
`ifdef BUF_SEQ_TIMEOUT_EN
    logic             w_others;
`endif

    rr_arbiter #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_winner (w_arb_winner),
        .o_idx    (w_arb_idx)
    );

    assign w_req_sel = req[r_sel];
    // Next search starts just after the channel being released.
    assign w_ptr_inc = (r_sel == C_LAST) ? C_IDX0 : (r_sel + C_IDX1);
`ifdef BUF_SEQ_TIMEOUT_EN
    assign w_others  = |(req & ~(C_LSB << r_sel));
`endif

    // Next-state, counter, selection and pointer logic.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_sel_next     = r_sel;
        w_ptr_next     = r_ptr;
        w_preempt_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_arb_winner) begin
                    w_state_next = ST_BREAK_IN;
                    w_sel_next   = w_arb_idx;
                    w_cnt_next   = C_DEAD;
                end else begin
                    w_cnt_next   = C_ZERO;
                end
            end
            ST_BREAK_IN: begin
                if (!w_req_sel) begin
                    // Abort before connection; still advance the pointer.
                    w_state_next = ST_BREAK_OUT;
                    w_cnt_next   = C_DEAD;
                    w_ptr_next   = w_ptr_inc;
                end else if (r_cnt <= C_ONE) begin
                    w_state_next = ST_SETTLE;
                    w_cnt_next   = C_SETTLE;
                end else begin
                    w_cnt_next   = r_cnt - C_ONE;
                end
            end
            ST_SETTLE: begin
                if (!w_req_sel) begin
                    w_state_next = ST_BREAK_OUT;
                    w_cnt_next   = C_DEAD;
                    w_ptr_next   = w_ptr_inc;
                end else if (r_cnt <= C_ONE) begin
                    w_state_next = ST_ACTIVE;
`ifdef BUF_SEQ_TIMEOUT_EN
                    w_cnt_next   = C_HOLD;
`else
                    w_cnt_next   = C_ZERO;
`endif
                end else begin
                    w_cnt_next   = r_cnt - C_ONE;
                end
            end
            ST_ACTIVE: begin
                if (!w_req_sel) begin
                    w_state_next = ST_BREAK_OUT;
                    w_cnt_next   = C_DEAD;
                    w_ptr_next   = w_ptr_inc;
`ifdef BUF_SEQ_TIMEOUT_EN
                end else if (r_cnt <= C_ONE) begin
                    // Hold budget spent: release only if someone else waits,
                    // otherwise the counter stays saturated at one.
                    if (w_others) begin
                        w_state_next   = ST_BREAK_OUT;
                        w_cnt_next     = C_DEAD;
                        w_ptr_next     = w_ptr_inc;
                        w_preempt_next = 1'b1;
                    end else begin
                        w_cnt_next     = r_cnt;
                    end
                end else begin
                    w_cnt_next   = r_cnt - C_ONE;
                end
`else
                end else begin
                    w_cnt_next   = r_cnt;
                end
`endif
            end
            ST_BREAK_OUT: begin
                if (r_cnt <= C_ONE) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = C_ZERO;
                end else begin
                    w_cnt_next   = r_cnt - C_ONE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = C_ZERO;
                w_sel_next   = C_IDX0;
                w_ptr_next   = C_IDX0;
            end
        endcase
    end

    // Switch enable / grant follows the next state so it changes on the
    // same edge as the state transition.
    always_comb begin
        if ((w_state_next == ST_SETTLE) || (w_state_next == ST_ACTIVE)) begin
            w_owner_next = C_LSB << w_sel_next;
        end else begin
            w_owner_next = {N_CH{1'b0}};
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= C_ZERO;
            r_sel     <= C_IDX0;
            r_ptr     <= C_IDX0;
            r_owner   <= {N_CH{1'b0}};
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_preempt <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_sel     <= w_sel_next;
            r_ptr     <= w_ptr_next;
            r_owner   <= w_owner_next;
            r_ready   <= (w_state_next == ST_ACTIVE);
            r_busy    <= (w_state_next != ST_IDLE);
            r_preempt <= w_preempt_next;
        end
    end

    // A single register feeds both so they can never disagree.
    assign grant   = r_owner;
    assign sw_en   = r_owner;
    assign ready   = r_ready;
    assign busy    = r_busy;
    assign preempt = r_preempt;

endmodule

// File: tb/tb_buf_mux_sequencer.sv
// ---------------------------------------------------------------------------
// tb_buf_mux_sequencer
// Directed bench for buf_mux_sequencer with default parameters
// (N_CH=4, DEAD_CYC=2, SETTLE_CYC=8, HOLD_MAX=64). Edge numbers count rising
// clock edges after reset release; outputs are sampled 1 time unit after
// the edge.
// ---------------------------------------------------------------------------
module tb_buf_mux_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] grant;
    logic [3:0] sw_en;
    logic       ready;
    logic       busy;
    logic       preempt;

    int checks = 0;
    int errors = 0;
    int ecount = 0;

    typedef struct {
        int         adv;
        logic [3:0] req;
        logic [3:0] sw;
        logic       rdy;
        logic       bsy;
    } vec_t;

    vec_t vecs[9];
    int   rr_order[5];

    buf_mux_sequencer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .grant   (grant),
        .sw_en   (sw_en),
        .ready   (ready),
        .busy    (busy),
        .preempt (preempt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d got=%0h expected=%0h", name, ecount, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [3:0] sw, input logic rdy, input logic bsy);
        chk({name, "_sw_en"},   {4'd0, sw_en},   {4'd0, sw});
        chk({name, "_grant"},   {4'd0, grant},   {4'd0, sw});
        chk({name, "_ready"},   {7'd0, ready},   {7'd0, rdy});
        chk({name, "_busy"},    {7'd0, busy},    {7'd0, bsy});
        chk({name, "_preempt"}, {7'd0, preempt}, 8'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ecount++;
    endtask

    task automatic adv(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0000;
        #2;
        chk_all("reset", 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n  = 1'b1;
        ecount = 0;
    endtask

    function automatic int idx_of(input logic [3:0] v);
        int r;
        r = -1;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog edge=%0d", ecount);
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int ngr;
        int gap;
        int hold;
        int owner;
        logic [3:0] prev;
        logic seen;

        // Single request on channel 1, released after edge 20.
        vecs[0] = '{1, 4'b0010, 4'b0000, 1'b0, 1'b1};  // edge 1: BREAK_IN
        vecs[1] = '{1, 4'b0010, 4'b0000, 1'b0, 1'b1};  // edge 2
        vecs[2] = '{1, 4'b0010, 4'b0010, 1'b0, 1'b1};  // edge 3: switch closes
        vecs[3] = '{7, 4'b0010, 4'b0010, 1'b0, 1'b1};  // edge 10: still settling
        vecs[4] = '{1, 4'b0010, 4'b0010, 1'b1, 1'b1};  // edge 11: ready
        vecs[5] = '{9, 4'b0010, 4'b0010, 1'b1, 1'b1};  // edge 20
        vecs[6] = '{1, 4'b0000, 4'b0000, 1'b0, 1'b1};  // edge 21: release
        vecs[7] = '{1, 4'b0000, 4'b0000, 1'b0, 1'b1};  // edge 22
        vecs[8] = '{2, 4'b0000, 4'b0000, 1'b0, 1'b0};  // edge 24: idle
        rr_order = '{0, 1, 2, 3, 0};

        rst_n = 1'b0;
        req   = 4'b0000;
        do_reset();

        for (int i = 0; i < 9; i++) begin
            req = vecs[i].req;
            adv(vecs[i].adv);
            chk_all($sformatf("single_v%0d", i), vecs[i].sw, vecs[i].rdy, vecs[i].bsy);
        end

        // Pointer now sits at 2. Reconnect channel 1, then reset mid-ACTIVE.
        req = 4'b0010;
        adv(12);                                        // edge 36: ACTIVE
        chk_all("pre_async", 4'b0010, 1'b1, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;                                             // well before next edge
        chk_all("async_rst", 4'b0000, 1'b0, 1'b0);
        #10;
        @(negedge clk);
        rst_n  = 1'b1;
        ecount = 0;
        req    = 4'b1111;
        adv(3);
        chk_all("ptr_restart", 4'b0001, 1'b0, 1'b1);

        // Round-robin with all channels requesting.
        do_reset();
        req  = 4'b1111;
        ngr  = 0;
        gap  = 0;
        hold = -1;
        owner = 0;
        prev = 4'b0000;
        for (int cyc = 0; cyc < 400 && ngr < 5; cyc++) begin
            tick();
            chk("rr_onehot", {7'd0, ($countones(sw_en) <= 1)}, 8'd1);
            chk("rr_grant_eq_sw", {4'd0, grant}, {4'd0, sw_en});
            if ((sw_en != 4'b0000) && (prev == 4'b0000)) begin
                owner = idx_of(sw_en);
                chk($sformatf("rr_order%0d", ngr), 8'(owner), 8'(rr_order[ngr]));
                if (ngr > 0) begin
                    chk("rr_gap", {7'd0, (gap >= 5)}, 8'd1);
                end
                ngr++;
                gap  = 0;
                hold = -1;
            end else if (sw_en == 4'b0000) begin
                gap++;
            end
            if (ready && (hold < 0)) begin
                hold = 5;
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) req[owner] = 1'b0;
            end
            if ((sw_en == 4'b0000) && (req != 4'b1111)) req = 4'b1111;
            prev = sw_en;
        end
        chk("rr_grant_count", 8'(ngr), 8'd5);

        // Abort during SETTLE, then a contended re-grant.
        do_reset();
        req  = 4'b0001;
        seen = 1'b0;
        for (int e = 0; e < 6; e++) begin
            tick();
            seen = seen | ready;
        end
        chk_all("abort_e6", 4'b0001, 1'b0, 1'b1);
        req = 4'b0000;
        tick();
        chk_all("abort_e7", 4'b0000, 1'b0, 1'b1);
        req = 4'b0011;
        for (int e = 0; e < 20 && sw_en == 4'b0000; e++) begin
            tick();
            seen = seen | ready;
        end
        chk("abort_no_ready", {7'd0, seen}, 8'd0);
        chk("abort_next_owner", {4'd0, sw_en}, 8'h02);
        chk("abort_next_edge", 8'(ecount), 8'd12);

        // Long hold on channel 2 with channel 3 contending from ACTIVE+10.
        do_reset();
        req = 4'b0100;
        adv(11);
        chk_all("hold_active", 4'b0100, 1'b1, 1'b1);
        adv(10);
        req = 4'b1100;
`ifdef BUF_SEQ_TIMEOUT_EN
        adv(53);                                        // edge 74
        chk_all("to_e74", 4'b0100, 1'b1, 1'b1);
        tick();                                         // edge 75
        chk("to_preempt_hi", {7'd0, preempt}, 8'd1);
        chk("to_sw_off", {4'd0, sw_en}, 8'h00);
        chk("to_ready_off", {7'd0, ready}, 8'd0);
        tick();                                         // edge 76
        chk("to_preempt_lo", {7'd0, preempt}, 8'd0);
        adv(3);                                         // edge 79
        chk_all("to_e79", 4'b0000, 1'b0, 1'b1);
        tick();                                         // edge 80
        chk_all("to_e80", 4'b1000, 1'b0, 1'b1);
`else
        for (int e = 0; e < 79; e++) begin
            tick();
            if ((ecount % 10) == 0) chk_all($sformatf("keep_e%0d", ecount), 4'b0100, 1'b1, 1'b1);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
